dmem_arbiter: RTL and testbench

//  Two-requester arbiter in front of the single-port data memory (registered read, 1-cycle latency).

---
 rtl/dmem_arb_pkg.sv | 30 +++
 rtl/dmem_arb_sat_cnt.sv | 35 +++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM state, read-return owner,
// and the per-requester bus payload.
package dmem_arb_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned DEF_MAX_WAIT = 4;
    localparam int unsigned DEF_WAIT_W   = 3;
    localparam int unsigned DEF_LOCK_MAX = 16;
    localparam int unsigned DEF_LOCK_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CPU_OWN    = 2'd1,
        ST_DMA_OWN    = 2'd2,
        ST_DMA_LOCKED = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module dmem_arb_sat_cnt #(
    parameter int unsigned W   = 3,
    parameter int unsigned MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter in front of the single-port data memory; CPU has priority, bounded by a
// DMA starvation counter and a cap on DMA lock length. Read data is routed to its owner.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
    parameter int unsigned WAIT_W   = DEF_WAIT_W,
    parameter int unsigned LOCK_MAX = DEF_LOCK_MAX,
    parameter int unsigned LOCK_W   = DEF_LOCK_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              locked, lock_cap, wait_full;
    logic              cpu_sel, dma_sel, any_gnt;
    mem_req_t          cpu_bus, dma_bus, sel_bus;

    assign locked    = (state_q == ST_DMA_LOCKED);
    assign lock_cap  = (lock_cnt == LOCK_W'(LOCK_MAX));
    assign wait_full = (wait_cnt == WAIT_W'(MAX_WAIT));

    // Priority grant, first match wins.
    always_comb begin
        cpu_sel = 1'b0;
        dma_sel = 1'b0;
        if (locked && dma_req && (lock_cnt < LOCK_W'(LOCK_MAX))) begin
            dma_sel = 1'b1;
        end else if (locked && lock_cap && cpu_req) begin
            cpu_sel = 1'b1;
        end else if (dma_req && wait_full) begin
            dma_sel = 1'b1;
        end else if (cpu_req) begin
            cpu_sel = 1'b1;
        end else if (dma_req) begin
            dma_sel = 1'b1;
        end
    end

    assign cpu_gnt   = rst_n & cpu_sel;
    assign dma_gnt   = rst_n & dma_sel;
    assign any_gnt   = cpu_gnt | dma_gnt;
    // Stall is also held low in reset so every output reads 0 while rst_n is asserted.
    assign cpu_stall = rst_n & cpu_req & ~cpu_gnt;

    assign cpu_bus = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    assign dma_bus = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
    assign sel_bus = cpu_gnt ? cpu_bus : (dma_gnt ? dma_bus : '0);

    assign mem_addr  = sel_bus.addr;
    assign mem_wdata = sel_bus.wdata;
    assign mem_write = any_gnt & sel_bus.we;
    assign mem_read  = any_gnt & ~sel_bus.we;

    // Next owner and read-return tag.
    always_comb begin
        state_d    = ST_IDLE;
        rd_owner_d = OWN_NONE;
        if (cpu_gnt) begin
            state_d = ST_CPU_OWN;
        end else if (dma_gnt) begin
            if (dma_lock) begin
                state_d = ST_DMA_LOCKED;
            end else if (locked) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_DMA_OWN;
            end
        end
        if (cpu_gnt && !cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (dma_gnt && !dma_we) begin
            rd_owner_d = OWN_DMA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    dmem_arb_sat_cnt #(.W(WAIT_W), .MAX(MAX_WAIT)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (dma_gnt | ~dma_req),
        .inc   (dma_req & ~dma_gnt),
        .cnt   (wait_cnt)
    );

    // Counts locked grants including the one that enters the lock.
    dmem_arb_sat_cnt #(.W(LOCK_W), .MAX(LOCK_MAX)) u_lock_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_d != ST_DMA_LOCKED),
        .inc   (dma_gnt & dma_lock),
        .cnt   (lock_cnt)
    );

    assign cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign dma_rvalid = (rd_owner_q == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small registered-read memory model behind it.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:63];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic lk, input logic [31:0] a,
                           input logic [31:0] d);
        dma_req = req; dma_we = we; dma_lock = lk; dma_addr = a; dma_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] exp_dma;
        logic        e;
        logic        prev_cpu;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem_rdata = '0;
        rst_n = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // 1: reset asserted while a CPU read is in flight
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t1_gnt", 32'(cpu_gnt), 32'd1);
        chk("t1_mem_read", 32'(mem_read), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_gnt_in_rst", 32'(cpu_gnt), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("t1_rdata", cpu_rdata, 32'd0);
        chk("t1_stall", 32'(cpu_stall), 32'd0);
        chk("t1_mem_read_rst", 32'(mem_read), 32'd0);
        chk("t1_mem_addr_rst", mem_addr, 32'd0);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst_n = 1'b1;

        // 6: idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_mem_read", 32'(mem_read), 32'd0);
            chk("t6_mem_write", 32'(mem_write), 32'd0);
            chk("t6_state", 32'(dut.state_q), 32'd0);
            chk("t6_wait_cnt", 32'(dut.wait_cnt), 32'd0);
            chk("t6_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            next_cycle();
        end

        // 2: CPU write then read back
        set_cpu(1'b1, 1'b1, 32'h04, 32'hDEADBEEF);
        @(negedge clk);
        chk("t2_wr_gnt", 32'(cpu_gnt), 32'd1);
        chk("t2_mem_write", 32'(mem_write), 32'd1);
        chk("t2_mem_read_wr", 32'(mem_read), 32'd0);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        next_cycle();
        set_cpu(1'b1, 1'b0, 32'h04, 32'h0);
        @(negedge clk);
        chk("t2_rd_mem_read", 32'(mem_read), 32'd1);
        chk("t2_rd_mem_write", 32'(mem_write), 32'd0);
        chk("t2_no_rvalid_wr", 32'(cpu_rvalid), 32'd0);
        next_cycle();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t2_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t2_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t2_dma_rdata", dma_rdata, 32'd0);
        chk("t2_dma_rvalid", 32'(dma_rvalid), 32'd0);
        next_cycle();

        // 3: continuous contention, DMA every 5th cycle
        set_cpu(1'b1, 1'b0, 32'h04, 32'h0);
        set_dma(1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
        for (int i = 0; i < 15; i++) begin
            e = ((i % 5) == 4);
            @(negedge clk);
            chk("t3_dma_gnt", 32'(dma_gnt), 32'(e));
            chk("t3_cpu_gnt", 32'(cpu_gnt), 32'(!e));
            chk("t3_cpu_stall", 32'(cpu_stall), 32'(e));
            next_cycle();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();

        // 4: locked DMA against a held CPU request
        exp_dma = 25'b1_0000_1111_1111_1111_1111_0000;
        set_cpu(1'b1, 1'b0, 32'h04, 32'h0);
        set_dma(1'b1, 1'b0, 1'b1, 32'h04, 32'h0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("t4_dma_gnt", 32'(dma_gnt), 32'(exp_dma[i]));
            chk("t4_cpu_gnt", 32'(cpu_gnt), 32'(!exp_dma[i]));
            if (i == 20) chk("t4_lock_cap", 32'(dut.lock_cnt), 32'd16);
            next_cycle();
        end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_no_gnt", 32'(dma_gnt | cpu_gnt), 32'd0);
        next_cycle();
        next_cycle();

        // 5: preload, then alternating reads
        set_cpu(1'b1, 1'b1, 32'h08, 32'h11112222);
        @(negedge clk);
        chk("t5_cpu_wr", 32'(mem_write), 32'd1);
        next_cycle();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_dma(1'b1, 1'b1, 1'b0, 32'h0C, 32'h33334444);
        @(negedge clk);
        chk("t5_dma_wr_gnt", 32'(dma_gnt), 32'd1);
        chk("t5_dma_wr_addr", mem_addr, 32'h0C);
        next_cycle();
        for (int k = 0; k < 7; k++) begin
            if (k < 6 && (k % 2) == 0) begin
                set_cpu(1'b1, 1'b0, 32'h08, 32'h0);
                set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if (k < 6) begin
                set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
                set_dma(1'b1, 1'b0, 1'b0, 32'h0C, 32'h0);
            end else begin
                set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
                set_dma(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            @(negedge clk);
            chk("t5_rd_and_wr", 32'(mem_read & mem_write), 32'd0);
            if (k < 6) begin
                chk("t5_gnt", 32'((k % 2) == 0 ? cpu_gnt : dma_gnt), 32'd1);
                chk("t5_addr", mem_addr, ((k % 2) == 0) ? 32'h08 : 32'h0C);
            end
            if (k > 0) begin
                prev_cpu = (((k - 1) % 2) == 0);
                chk("t5_cpu_rvalid", 32'(cpu_rvalid), 32'(prev_cpu));
                chk("t5_dma_rvalid", 32'(dma_rvalid), 32'(!prev_cpu));
                chk("t5_cpu_rdata", cpu_rdata, prev_cpu ? 32'h11112222 : 32'h0);
                chk("t5_dma_rdata", dma_rdata, prev_cpu ? 32'h0 : 32'h33334444);
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
